// File: rtl/int_request_unit.sv
// Interrupt request unit: reset sequencing, NMI edge capture and maskable IRQ arbitration.
// Define INTU_NMI_EN to build the NMI synchroniser/pending logic; otherwise NMI_in is ignored.
module int_request_unit #(
  parameter int                   N_IRQ     = 8,
  parameter int                   RST_HOLD  = 4,
  parameter int                   ADDR_BITS = 16,
  parameter logic [ADDR_BITS-1:0] RST_VEC   = 16'hFFFE,
  parameter logic [ADDR_BITS-1:0] NMI_VEC   = 16'hFFFC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 IF,
  input  logic                 GIE,
  input  logic                 INTACK,
  input  logic                 NMI_in,
  input  logic [N_IRQ-1:0]     irq,
  output logic                 rst,
  output logic                 INTREQ,
  output logic [ADDR_BITS-1:0] INTVEC,
  output logic [N_IRQ-1:0]     IRQ_CLR
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CNT_W = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_RSTWAIT,
    S_IDLE,
    S_ARB,
    S_LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 lock_nmi_q, lock_nmi_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
  logic [ADDR_BITS-1:0] vec_q;

  logic                 nmi_req;
  logic                 nmi_clr;
  logic [N_IRQ-1:0]     irq_qual;
  logic                 irq_any;
  logic [IDX_W-1:0]     irq_idx;
  logic                 any_req;
  logic [ADDR_BITS-1:0] win_vec;

  function automatic logic [ADDR_BITS-1:0] irq_vec(input logic [IDX_W-1:0] idx);
    return NMI_VEC - ADDR_BITS'(2 * (N_IRQ - int'(idx)));
  endfunction

`ifdef INTU_NMI_EN
  logic [2:0] nmi_sync_q;
  logic       nmi_rise;
  logic       nmi_pend_q, nmi_pend_d;

  // Two-flop synchroniser followed by a history flop for rising-edge detection.
  assign nmi_rise   = nmi_sync_q[1] & ~nmi_sync_q[2];
  assign nmi_pend_d = nmi_rise | (nmi_pend_q & ~nmi_clr);
  assign nmi_req    = nmi_pend_q | nmi_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_q <= '0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_sync_q <= {nmi_sync_q[1:0], NMI_in};
      nmi_pend_q <= nmi_pend_d;
    end
  end
`else
  logic unused_nmi;

  assign nmi_req    = 1'b0;
  assign unused_nmi = NMI_in ^ nmi_clr;
`endif

  // Fixed priority: NMI above all, then the highest-numbered qualified irq line.
  always_comb begin
    irq_qual = irq & {N_IRQ{GIE}};
    irq_any  = |irq_qual;
    irq_idx  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_qual[i]) irq_idx = IDX_W'(i);
    end
    any_req = nmi_req | irq_any;
    win_vec = nmi_req ? NMI_VEC : irq_vec(irq_idx);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_nmi_d = lock_nmi_q;
    lock_idx_d = lock_idx_q;
    nmi_clr    = 1'b0;
    rst        = 1'b0;
    INTREQ     = 1'b0;
    INTVEC     = vec_q;
    IRQ_CLR    = '0;
    case (state_q)
      S_RESET: begin
        rst = 1'b1;
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = S_RSTWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RSTWAIT: begin
        if (INTACK) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (any_req) begin
          INTVEC  = win_vec;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!any_req) begin
          state_d = S_IDLE;
        end else begin
          INTREQ = 1'b1;
          INTVEC = win_vec;
          if (IF) begin
            state_d    = S_LOCKED;
            lock_nmi_d = nmi_req;
            lock_idx_d = irq_idx;
          end
        end
      end
      S_LOCKED: begin
        INTREQ = 1'b1;
        if (INTACK) begin
          state_d = S_IDLE;
          if (lock_nmi_q) nmi_clr = 1'b1;
          else            IRQ_CLR = N_IRQ'(1) << lock_idx_q;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // vec_q tracks the presented vector so LOCKED holds it and reset restores RST_VEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      lock_nmi_q <= 1'b0;
      lock_idx_q <= '0;
      vec_q      <= RST_VEC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_nmi_q <= lock_nmi_d;
      lock_idx_q <= lock_idx_d;
      vec_q      <= INTVEC;
    end
  end

endmodule
